// File: rtl/le18_port_ctrl.sv
// LE18 graphics port controller: decodes Z80 OUT/IN cycles into RAM port-A strobes.
// Define LE18_FILL_EN to build the background fill engine and busy output.
module le18_port_ctrl #(
  parameter int COLS = 64,
  parameter int ROWS = 192
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        io_access,
  input  logic [7:0]  TRS_A,
  input  logic [7:0]  TRS_D,
  input  logic        TRS_OUT,
  input  logic        TRS_IN,
  output logic        ram_ce,
  output logic        ram_we,
  output logic        ram_oce,
  output logic [13:0] ram_addr,
  output logic [5:0]  ram_din,
  output logic        dout_rdy,
  output logic        busy
);

  localparam logic [5:0] X_MAX = 6'(COLS - 1);
  localparam logic [7:0] Y_MAX = 8'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, WR, RD1, RD2, RD3
`ifdef LE18_FILL_EN
    , FILL
`endif
  } state_t;

  state_t      state, state_nxt, ret_state;
  logic        io_q;
  logic [5:0]  x;
  logic [7:0]  y;
  logic        autoinc;
  logic [5:0]  din_q;
  logic        rise, out_hit, in_hit, data_ok, wr_go, rd_go, ctl_wr;

  assign rise    = io_access & ~io_q;
  assign out_hit = rise & ~TRS_OUT;
  assign in_hit  = rise & ~TRS_IN;
  assign ctl_wr  = out_hit & (TRS_A == 8'hEB);
  assign wr_go   = out_hit & (TRS_A == 8'hEC) & data_ok;
  assign rd_go   = in_hit  & (TRS_A == 8'hEC) & data_ok;

`ifdef LE18_FILL_EN
  logic       busy_q, fill_go, fill_last;
  logic [5:0] fx, pattern;
  logic [7:0] fy;

  assign data_ok   = (state == IDLE) || (state == FILL);
  assign fill_go   = ctl_wr & TRS_D[1] & ~busy_q;
  assign fill_last = (fx == X_MAX) && (fy == Y_MAX);
  assign ret_state = busy_q ? FILL : IDLE;
  assign busy      = busy_q & ~srst;

  // Fill address runs on its own counter; Z80 cycles only stall it.
  always_ff @(posedge clk) begin
    if (srst) begin
      busy_q  <= 1'b0;
      fx      <= '0;
      fy      <= '0;
      pattern <= '0;
    end else if (fill_go) begin
      busy_q  <= 1'b1;
      fx      <= '0;
      fy      <= '0;
      pattern <= TRS_D[7:2];
    end else if (state == FILL) begin
      if (fill_last) busy_q <= 1'b0;
      else if (fx == X_MAX) begin
        fx <= '0;
        fy <= fy + 8'd1;
      end else fx <= fx + 6'd1;
    end
  end
`else
  assign data_ok   = (state == IDLE);
  assign ret_state = IDLE;
  assign busy      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_oce   = 1'b0;
    dout_rdy  = 1'b0;
    ram_addr  = {y, x};
    ram_din   = din_q;
    case (state)
      IDLE: begin
        if (wr_go) state_nxt = WR;
        else if (rd_go) state_nxt = RD1;
`ifdef LE18_FILL_EN
        else if (fill_go || busy_q) state_nxt = FILL;
`endif
      end
      WR: begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        state_nxt = ret_state;
      end
      RD1: begin
        ram_ce    = 1'b1;
        state_nxt = RD2;
      end
      RD2: begin
        ram_oce   = 1'b1;
        state_nxt = RD3;
      end
      RD3: begin
        dout_rdy  = 1'b1;
        state_nxt = ret_state;
      end
`ifdef LE18_FILL_EN
      FILL: begin
        ram_ce   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = {fy, fx};
        ram_din  = pattern;
        if (wr_go) state_nxt = WR;
        else if (rd_go) state_nxt = RD1;
        else if (fill_last) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // Reset kills strobes in the same cycle so an aborted op never touches RAM.
    if (srst) begin
      ram_ce   = 1'b0;
      ram_we   = 1'b0;
      ram_oce  = 1'b0;
      dout_rdy = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state   <= IDLE;
      io_q    <= 1'b0;
      x       <= '0;
      y       <= '0;
      autoinc <= 1'b0;
      din_q   <= '0;
    end else begin
      state <= state_nxt;
      io_q  <= io_access;
      if (autoinc && (state == WR || state == RD1)) begin
        if (x == X_MAX) begin
          x <= '0;
          y <= (y == Y_MAX) ? 8'd0 : y + 8'd1;
        end else x <= x + 6'd1;
      end
      // Register writes come after autoinc so they win on a collision.
      if (out_hit && TRS_A == 8'hED) x <= TRS_D[5:0];
      if (out_hit && TRS_A == 8'hEE) y <= TRS_D;
      if (ctl_wr) autoinc <= TRS_D[0];
      if (wr_go) din_q <= TRS_D[5:0];
    end
  end

endmodule

// File: tb/tb_le18_port_ctrl.sv
// Self-checking bench for le18_port_ctrl: behavioural RAM + coordinate model, random Z80 traffic.
module tb_le18_port_ctrl;
  logic clk = 1'b0;
  logic srst, io_access, TRS_OUT, TRS_IN;
  logic [7:0] TRS_A, TRS_D;
  logic ram_ce, ram_we, ram_oce, dout_rdy, busy;
  logic [13:0] ram_addr;
  logic [5:0] ram_din;

  le18_port_ctrl #(.COLS(64), .ROWS(192)) dut (
    .clk(clk), .srst(srst), .io_access(io_access), .TRS_A(TRS_A), .TRS_D(TRS_D),
    .TRS_OUT(TRS_OUT), .TRS_IN(TRS_IN), .ram_ce(ram_ce), .ram_we(ram_we),
    .ram_oce(ram_oce), .ram_addr(ram_addr), .ram_din(ram_din),
    .dout_rdy(dout_rdy), .busy(busy));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // RAM model with output register, plus activity monitors
  logic [5:0]  mem [0:16383] = '{default: 6'd0};
  int          wcnt [0:16383] = '{default: 0};
  int          wr_total = 0, rd_cnt = 0, busy_cyc = 0;
  logic [5:0]  q1 = '0, douta = '0, last_rd = '0, last_wdin = '0;
  logic [13:0] last_waddr = '0;

  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      mem[ram_addr]  <= ram_din;
      wcnt[ram_addr] <= wcnt[ram_addr] + 1;
      wr_total       <= wr_total + 1;
      last_waddr     <= ram_addr;
      last_wdin      <= ram_din;
    end
    if (ram_ce && !ram_we) q1 <= mem[ram_addr];
    if (ram_oce) douta <= q1;
    if (dout_rdy) begin
      rd_cnt  <= rd_cnt + 1;
      last_rd <= douta;
    end
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  // Reference model: coordinates and expected memory contents
  logic [5:0] exp_mem [0:16383] = '{default: 6'd0};
  int  mx = 0, my = 0;
  bit  mauto = 0;
  int  wsnap [0:16383];

  function automatic int maddr();
    return my * 64 + mx;
  endfunction

  function automatic void m_adv();
    if (mauto) begin
      mx = mx + 1;
      if (mx == 64) begin
        mx = 0;
        my = (my == 191) ? 0 : my + 1;
      end
    end
  endfunction

  task automatic z80(input bit is_in, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    TRS_A = a; TRS_D = d; TRS_OUT = is_in; TRS_IN = !is_in; io_access = 1'b1;
    repeat (2) @(negedge clk);
    io_access = 1'b0; TRS_OUT = 1'b1; TRS_IN = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic out_op(input logic [7:0] a, input logic [7:0] d);
    z80(1'b0, a, d);
    case (a)
      8'hED: mx = int'(d[5:0]);
      8'hEE: my = int'(d);
      8'hEB: mauto = d[0];
      8'hEC: begin exp_mem[maddr()] = d[5:0]; m_adv(); end
      default: ;
    endcase
  endtask

  task automatic in_op(output logic [5:0] e);
    e = exp_mem[maddr()];
    m_adv();
    z80(1'b1, 8'hEC, 8'h00);
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_ce, ram_we, ram_oce, dout_rdy, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000", {ram_ce, ram_we, ram_oce, dout_rdy, busy});
    end
    srst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ram_ce, ram_we, ram_oce, dout_rdy, busy} !== 5'b0) begin
      errors++; $display("FAIL post_reset_idle: got %b want 00000", {ram_ce, ram_we, ram_oce, dout_rdy, busy});
    end
    mx = 0; my = 0; mauto = 0;
  endtask

  task automatic test_write();
    out_op(8'hED, 8'd5);
    out_op(8'hEE, 8'd10);
    @(negedge clk);
    TRS_A = 8'hEC; TRS_D = 8'h2A; TRS_OUT = 1'b0; io_access = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ram_ce, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, 14'h0285, 6'h2A}) begin
      errors++; $display("FAIL write_cycle: ce=%b we=%b addr=%h din=%h want 1 1 0285 2a", ram_ce, ram_we, ram_addr, ram_din);
    end
    @(posedge clk); #1;
    checks++;
    if ({ram_ce, ram_we} !== 2'b00) begin
      errors++; $display("FAIL write_one_cycle: ce/we=%b want 00", {ram_ce, ram_we});
    end
    @(negedge clk);
    io_access = 1'b0; TRS_OUT = 1'b1;
    repeat (2) @(negedge clk);
    exp_mem[10 * 64 + 5] = 6'h2A;
  endtask

  task automatic test_read();
    out_op(8'hED, 8'd3);
    out_op(8'hEE, 8'd7);
    out_op(8'hEC, 8'h19);
    @(negedge clk);
    TRS_A = 8'hEC; TRS_IN = 1'b0; io_access = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ram_ce, ram_we, ram_oce, dout_rdy} !== 4'b1000 || ram_addr !== 14'(7 * 64 + 3)) begin
      errors++; $display("FAIL read_edge1: ce/we/oce/rdy=%b addr=%h want 1000 %h", {ram_ce, ram_we, ram_oce, dout_rdy}, ram_addr, 14'(7 * 64 + 3));
    end
    @(posedge clk); #1;
    checks++;
    if ({ram_ce, ram_we, ram_oce, dout_rdy} !== 4'b0010) begin
      errors++; $display("FAIL read_edge2: ce/we/oce/rdy=%b want 0010", {ram_ce, ram_we, ram_oce, dout_rdy});
    end
    @(posedge clk); #1;
    checks++;
    if ({ram_ce, ram_we, ram_oce, dout_rdy} !== 4'b0001 || douta !== 6'h19) begin
      errors++; $display("FAIL read_edge3: ce/we/oce/rdy=%b data=%h want 0001 19", {ram_ce, ram_we, ram_oce, dout_rdy}, douta);
    end
    @(posedge clk); #1;
    checks++;
    if ({ram_ce, ram_we, ram_oce, dout_rdy} !== 4'b0000) begin
      errors++; $display("FAIL read_done: ce/we/oce/rdy=%b want 0000", {ram_ce, ram_we, ram_oce, dout_rdy});
    end
    @(negedge clk);
    io_access = 1'b0; TRS_IN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_autoinc();
    out_op(8'hEB, 8'h01);
    out_op(8'hED, 8'd63);
    out_op(8'hEE, 8'd191);
    out_op(8'hEC, 8'h05);
    checks++;
    if (last_waddr !== 14'(191 * 64 + 63)) begin
      errors++; $display("FAIL autoinc_last_addr: got %h want %h", last_waddr, 14'(191 * 64 + 63));
    end
    out_op(8'hEC, 8'h06);
    checks++;
    if (last_waddr !== 14'h0000 || last_wdin !== 6'h06) begin
      errors++; $display("FAIL autoinc_full_wrap: addr=%h din=%h want 0000 06", last_waddr, last_wdin);
    end
    out_op(8'hED, 8'd63);
    out_op(8'hEE, 8'd4);
    out_op(8'hEC, 8'h07);
    out_op(8'hEC, 8'h08);
    checks++;
    if (last_waddr !== 14'(5 * 64) || last_wdin !== 6'h08) begin
      errors++; $display("FAIL autoinc_row_wrap: addr=%h din=%h want %h 08", last_waddr, last_wdin, 14'(5 * 64));
    end
  endtask

  task automatic test_random();
    int w0, mw, r0, bad;
    logic [5:0] e;
    logic [7:0] d;
    w0 = wr_total; mw = 0;
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom);
      case ($urandom_range(0, 5))
        0: out_op(8'hED, ($urandom_range(0, 1) == 1) ? 8'(60 + $urandom_range(0, 3)) : d);
        1: out_op(8'hEE, ($urandom_range(0, 1) == 1) ? 8'(188 + $urandom_range(0, 3)) : 8'($urandom_range(0, 191)));
        2: out_op(8'hEB, d & 8'hFD);
        3, 4: begin out_op(8'hEC, d); mw++; end
        default: begin
          r0 = rd_cnt;
          in_op(e);
          checks++;
          if (rd_cnt !== r0 + 1 || last_rd !== e) begin
            errors++; $display("FAIL rand_read %0d: pulses=%0d data=%h want 1 %h", i, rd_cnt - r0, last_rd, e);
          end
        end
      endcase
    end
    checks++;
    if (wr_total - w0 !== mw) begin
      errors++; $display("FAIL rand_write_count: got %0d want %0d", wr_total - w0, mw);
    end
    bad = 0;
    for (int a = 0; a < 16384; a++) if (mem[a] !== exp_mem[a]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rand_mem_image: %0d words differ, want 0", bad);
    end
  endtask

  task automatic test_read_reset();
    int r0, w0;
    r0 = rd_cnt; w0 = wr_total;
    @(negedge clk);
    TRS_A = 8'hEC; TRS_IN = 1'b0; io_access = 1'b1;
    @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0; io_access = 1'b0; TRS_IN = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (rd_cnt !== r0 || wr_total !== w0) begin
      errors++; $display("FAIL read_abort: rdy pulses=%0d writes=%0d want 0 0", rd_cnt - r0, wr_total - w0);
    end
    mx = 0; my = 0; mauto = 0;
  endtask

`ifdef LE18_FILL_EN
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20000) begin @(negedge clk); n++; end
    checks++;
    if (busy) begin
      errors++; $display("FAIL %s_timeout: busy still 1 after %0d cycles want 0", tag, n);
    end
  endtask

  task automatic check_fill(input string tag, input logic [5:0] pat);
    int bad = 0;
    for (int a = 0; a < 16384; a++) begin
      if (wcnt[a] - wsnap[a] != ((a < 12288) ? 1 : 0)) bad++;
      if (a < 12288 && mem[a] !== pat) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s_words: %0d bad addresses want 0", tag, bad);
    end
    for (int a = 0; a < 12288; a++) exp_mem[a] = pat;
  endtask

  task automatic test_fill();
    int b0;
    for (int a = 0; a < 16384; a++) wsnap[a] = wcnt[a];
    b0 = busy_cyc;
    z80(1'b0, 8'hEB, 8'hFE);
    mauto = 0;
    wait_idle("fill");
    checks++;
    if (busy_cyc - b0 !== 12288) begin
      errors++; $display("FAIL fill_busy_len: got %0d want 12288", busy_cyc - b0);
    end
    check_fill("fill", 6'h3F);
    out_op(8'hEC, 8'h21);
    checks++;
    if (last_waddr !== 14'((my * 64 + mx + 16384 - 0) % 16384) && last_waddr !== 14'(maddr())) begin
      errors++; $display("FAIL fill_xy_kept: addr=%h want %h", last_waddr, 14'(maddr()));
    end
  endtask

  task automatic test_fill_stall();
    int b0, r0;
    logic [5:0] e;
    out_op(8'hED, 8'd3);
    out_op(8'hEE, 8'd7);
    for (int a = 0; a < 16384; a++) wsnap[a] = wcnt[a];
    b0 = busy_cyc;
    z80(1'b0, 8'hEB, 8'h56);
    mauto = 0;
    repeat (40) @(negedge clk);
    r0 = rd_cnt;
    in_op(e);
    checks++;
    if (rd_cnt !== r0 + 1 || last_rd !== e) begin
      errors++; $display("FAIL stall_read: pulses=%0d data=%h want 1 %h", rd_cnt - r0, last_rd, e);
    end
    wait_idle("stall");
    checks++;
    if (busy_cyc - b0 !== 12291) begin
      errors++; $display("FAIL stall_busy_len: got %0d want 12291", busy_cyc - b0);
    end
    check_fill("stall", 6'h15);
  endtask

  task automatic test_fill_reset();
    int w0;
    out_op(8'hED, 8'd9);
    out_op(8'hEE, 8'd9);
    z80(1'b0, 8'hEB, 8'hAA);
    repeat (95) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL freset_busy_before: got %b want 1", busy);
    end
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    w0 = wr_total;
    checks++;
    if (busy !== 1'b0 || ram_ce !== 1'b0) begin
      errors++; $display("FAIL freset_busy_after: busy=%b ce=%b want 0 0", busy, ram_ce);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (wr_total !== w0 || busy !== 1'b0) begin
      errors++; $display("FAIL freset_quiet: extra writes=%0d busy=%b want 0 0", wr_total - w0, busy);
    end
    z80(1'b0, 8'hEC, 8'h11);
    checks++;
    if (last_waddr !== 14'h0000 || wr_total !== w0 + 1) begin
      errors++; $display("FAIL freset_xy_zero: addr=%h writes=%0d want 0000 1", last_waddr, wr_total - w0);
    end
  endtask
`endif

  initial begin
    srst = 1'b1; io_access = 1'b0; TRS_OUT = 1'b1; TRS_IN = 1'b1;
    TRS_A = 8'h00; TRS_D = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_autoinc();
    test_random();
    test_read_reset();
`ifdef LE18_FILL_EN
    test_fill();
    test_fill_stall();
    test_fill_reset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
